// File: rtl/pdm_modulator.sv
// PCM-to-PDM converter: 2-deep sample FIFO feeding a saturating
// second-order sigma-delta modulator.
module pdm_modulator #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_bit,
  input  logic         en_pcm,
  input  logic [W-1:0] pcm_in,
  input  logic         pcm_valid,
  output logic         pcm_ready,
  input  logic         clr_underflow,
  output logic         pdm_out,
  output logic         underflow
);

  logic [W-1:0]        mem_q [2];
  logic                wp_q, wp_d;
  logic                rp_q, rp_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [W-1:0]        cur_q, cur_d;
  logic                und_q, und_d;
  logic signed [W+3:0] acc1_q, acc1_d;
  logic signed [W+7:0] acc2_q, acc2_d;
  logic                pdm_q, pdm_d;

  logic                full, empty, push, pop;
  logic signed [W+5:0] fb1, sum1;
  logic signed [W+9:0] fb2, sum2;
  logic signed [W+3:0] acc1n;
  logic signed [W+7:0] acc2n;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign push  = pcm_valid & ~full;
  assign pop   = en_pcm & ~empty;

  assign pcm_ready = ~full;
  assign pdm_out   = pdm_q;
  assign underflow = und_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    cur_d = cur_q;
    und_d = und_q;
    if (push) wp_d = ~wp_q;
    if (pop) begin
      rp_d  = ~rp_q;
      cur_d = mem_q[rp_q];
    end
    if (clr_underflow) und_d = 1'b0;
    // a starved pop wins over a coincident clear
    if (en_pcm && empty) und_d = 1'b1;
  end

  always_comb begin
    fb1 = pdm_q ? {{6{1'b0}}, 1'b1, {(W-1){1'b0}}}
                : {{7{1'b1}}, {(W-1){1'b0}}};
    fb2 = {{4{fb1[W+5]}}, fb1};
    sum1 = {{2{acc1_q[W+3]}}, acc1_q}
         + {{6{cur_q[W-1]}}, cur_q}
         - fb1;
    if (sum1[W+5:W+3] == 3'b000 || sum1[W+5:W+3] == 3'b111)
      acc1n = sum1[W+3:0];
    else
      acc1n = sum1[W+5] ? {1'b1, {(W+3){1'b0}}}
                        : {1'b0, {(W+3){1'b1}}};
    sum2 = {{2{acc2_q[W+7]}}, acc2_q}
         + {{6{acc1n[W+3]}}, acc1n}
         - fb2;
    if (sum2[W+9:W+7] == 3'b000 || sum2[W+9:W+7] == 3'b111)
      acc2n = sum2[W+7:0];
    else
      acc2n = sum2[W+9] ? {1'b1, {(W+7){1'b0}}}
                        : {1'b0, {(W+7){1'b1}}};
  end

  always_comb begin
    acc1_d = acc1_q;
    acc2_d = acc2_q;
    pdm_d  = pdm_q;
    if (en_bit) begin
      acc1_d = acc1n;
      acc2_d = acc2n;
      pdm_d  = ~acc2n[W+7];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
      cur_q    <= '0;
      und_q    <= 1'b0;
      acc1_q   <= '0;
      acc2_q   <= '0;
      pdm_q    <= 1'b0;
    end else begin
      if (push) mem_q[wp_q] <= pcm_in;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      cur_q  <= cur_d;
      und_q  <= und_d;
      acc1_q <= acc1_d;
      acc2_q <= acc2_d;
      pdm_q  <= pdm_d;
    end
  end

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed self-checking bench for pdm_modulator.
// Inputs change #1 after the rising edge; outputs sampled there too.
module tb_pdm_modulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_bit = 1'b0;
  logic        en_pcm = 1'b0;
  logic [15:0] pcm_in = '0;
  logic        pcm_valid = 1'b0;
  logic        pcm_ready;
  logic        clr_underflow = 1'b0;
  logic        pdm_out;
  logic        underflow;

  int n_chk = 0;
  int n_err = 0;

  pdm_modulator #(.W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .en_bit        (en_bit),
    .en_pcm        (en_pcm),
    .pcm_in        (pcm_in),
    .pcm_valid     (pcm_valid),
    .pcm_ready     (pcm_ready),
    .clr_underflow (clr_underflow),
    .pdm_out       (pdm_out),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    pcm_in = d;
    pcm_valid = 1'b1;
    tick();
    pcm_valid = 1'b0;
  endtask

  task automatic pcm_tick();
    en_pcm = 1'b1;
    tick();
    en_pcm = 1'b0;
  endtask

  task automatic run_bits(input int n, output int ones, output int zrun);
    int run;
    ones = 0;
    zrun = 0;
    run  = 0;
    en_bit = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (pdm_out) begin
        ones++;
        run = 0;
      end else begin
        run++;
        if (run > zrun) zrun = run;
      end
    end
    en_bit = 1'b0;
  endtask

  initial begin
    int ones, zrun;
    logic [3:0] seq;

    #2;
    tick();
    chk("rst_ready", int'(pcm_ready), 1);
    chk("rst_pdm", int'(pdm_out), 0);
    chk("rst_underflow", int'(underflow), 0);
    reset = 1'b0;

    // idle-channel start-up pattern from the zero state
    en_bit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      seq[3-i] = pdm_out;
    end
    en_bit = 1'b0;
    chk("zero_seq_1101", int'(seq), 4'b1101);

    // hold en_bit low: output must not move
    repeat (3) tick();
    chk("hold_no_bit", int'(pdm_out), 1);

    do_reset();
    push(16'h0000);
    pcm_tick();
    chk("zero_no_uf", int'(underflow), 0);
    run_bits(1024, ones, zrun);
    chk("zero_ones_range", int'(ones >= 508 && ones <= 516), 1);

    push(16'h4000);
    pcm_tick();
    run_bits(1024, ones, zrun);
    chk("half_ones_range", int'(ones >= 760 && ones <= 776), 1);

    do_reset();
    push(16'h7FFF);
    pcm_tick();
    run_bits(1000, ones, zrun);
    chk("full_ones_ge990", int'(ones >= 990), 1);
    chk("full_zero_run", int'(zrun <= 2), 1);

    // starved pop keeps the full-scale sample in place
    pcm_tick();
    chk("uf_set", int'(underflow), 1);
    run_bits(200, ones, zrun);
    chk("uf_cur_held", int'(ones >= 190), 1);
    clr_underflow = 1'b1;
    tick();
    clr_underflow = 1'b0;
    chk("uf_clear", int'(underflow), 0);
    clr_underflow = 1'b1;
    en_pcm = 1'b1;
    tick();
    clr_underflow = 1'b0;
    en_pcm = 1'b0;
    chk("uf_clr_vs_set", int'(underflow), 1);
    tick();
    chk("uf_sticky", int'(underflow), 1);

    // FIFO back-pressure
    do_reset();
    push(16'h0101);
    chk("ff_ready_1", int'(pcm_ready), 1);
    push(16'h0202);
    chk("ff_ready_2", int'(pcm_ready), 0);
    pcm_in = 16'h0303;
    pcm_valid = 1'b1;
    tick();
    chk("ff_held_off", int'(pcm_ready), 0);
    en_pcm = 1'b1;
    tick();
    en_pcm = 1'b0;
    chk("ff_pop_ready", int'(pcm_ready), 1);
    tick();
    pcm_valid = 1'b0;
    chk("ff_third_in", int'(pcm_ready), 0);
    pcm_tick();
    pcm_tick();
    chk("ff_three_pops", int'(underflow), 0);
    chk("ff_empty_ready", int'(pcm_ready), 1);
    pcm_tick();
    chk("ff_fourth_uf", int'(underflow), 1);

    // push and pop together leave occupancy unchanged
    do_reset();
    push(16'h1111);
    pcm_in = 16'h2222;
    pcm_valid = 1'b1;
    en_pcm = 1'b1;
    tick();
    pcm_valid = 1'b0;
    en_pcm = 1'b0;
    chk("pp_ready", int'(pcm_ready), 1);
    chk("pp_no_uf", int'(underflow), 0);
    pcm_tick();
    chk("pp_word_kept", int'(underflow), 0);

    // push into empty FIFO with en_pcm: no bypass, word stored
    do_reset();
    pcm_in = 16'h1234;
    pcm_valid = 1'b1;
    en_pcm = 1'b1;
    tick();
    pcm_valid = 1'b0;
    en_pcm = 1'b0;
    chk("nb_uf", int'(underflow), 1);
    chk("nb_ready", int'(pcm_ready), 1);
    push(16'h5678);
    chk("nb_stored", int'(pcm_ready), 0);

    // mid-stream reset with two samples buffered
    do_reset();
    push(16'h7FFF);
    pcm_tick();
    run_bits(10, ones, zrun);
    push(16'h0001);
    push(16'h0002);
    chk("mr_full", int'(pcm_ready), 0);
    chk("mr_pdm_pre", int'(pdm_out), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_ready_async", int'(pcm_ready), 1);
    chk("mr_pdm_async", int'(pdm_out), 0);
    tick();
    reset = 1'b0;
    pcm_tick();
    chk("mr_uf_after", int'(underflow), 1);
    en_bit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      seq[3-i] = pdm_out;
    end
    en_bit = 1'b0;
    chk("mr_restart_seq", int'(seq), 4'b1101);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
